// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
// This package holds the FSM state encoding, the transfer size codes and the
// requester port ids used by mem_arbiter and its testbench.

package mem_arbiter_pkg;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   // Transfer size codes carried on d_size / m_size.
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Requester ids, also the encoding driven on err_port.
   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   // True while a memory transfer is outstanding.
   function automatic logic is_busy(arb_state_t s);
      return (s == I_BUSY) || (s == D_BUSY);
   endfunction

endpackage

// File: rtl/mem_arbiter_bus_timeout.sv
// Bus timeout counter for the memory arbiter.
// Counts BUSY cycles that pass without a memory ack and flags expiry in the
// cycle that completes the TIMEOUT_CYC-th such cycle, so the FSM can leave
// BUSY on that same edge. TIMEOUT_CYC = 0 disables the timeout entirely.
// Because en is only asserted while no ack is present, an ack in the final
// cycle suppresses expiry and the ack wins.

module bus_timeout #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   // The counter only has to reach TIMEOUT_CYC-1 before expiry fires.
   localparam int CW    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
   localparam int LIMIT = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
   localparam logic [CW-1:0] LAST = CW'(LIMIT);

   logic [CW-1:0] count;

   // Clear on reset or while waiting to enter BUSY; count ack-less BUSY cycles.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en && !expired) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (TIMEOUT_CYC != 0) && en && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction fetch port and a data load/store
// port share one memory port. Each transaction runs IDLE -> BUSY -> RESP,
// with the requester's ack_n pulsed low for one cycle in RESP. A bus
// timeout (bus_timeout sub-module) ends a BUSY state that never sees an ack
// and reports it on bus_err/err_port during RESP.
//
// Build option: define MEM_ARB_RR_EN to break simultaneous requests in
// favour of the port that was not granted last. Without it the data port
// always wins a tie and no last-grant state exists.

module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ack_n,

   input  logic        d_req,
   input  logic        d_write,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack_n,

   output logic        m_req,
   output logic        m_write,
   output logic [1:0]  m_size,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_ack_n,

   output logic        bus_err,
   output logic        err_port
);

   arb_state_t state;
   arb_state_t state_next;

   logic winner;
   logic timed_out;
   logic tie_to_d;
   logic grant_d;
   logic grant_i;
   logic busy;
   logic ack_seen;
   logic timer_clr;
   logic timer_en;
   logic expired;

`ifdef MEM_ARB_RR_EN
   logic last_grant;

   // A tie goes to data only when fetch was the port granted last.
   assign tie_to_d = (last_grant == PORT_I);

   // Remember which port took the most recent grant, starting from data.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= PORT_D;
      end else if (state == IDLE && (grant_d || grant_i)) begin
         last_grant <= grant_d ? PORT_D : PORT_I;
      end
   end
`else
   assign tie_to_d = 1'b1;
`endif

   // Grant decisions are only acted upon in IDLE.
   assign grant_d = d_req && (!i_req || tie_to_d);
   assign grant_i = i_req && !grant_d;

   // Memory acks are only meaningful while a transfer is outstanding.
   assign busy     = is_busy(state);
   assign ack_seen = busy && !m_ack_n;

   assign timer_clr = (state == IDLE);
   assign timer_en  = busy && m_ack_n;

   bus_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_bus_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (timer_clr),
      .en      (timer_en),
      .expired (expired)
   );

   // FSM state register; reset abandons any transfer in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs; acks and error flags live only in RESP.
   always_comb begin
      state_next = state;
      m_req      = 1'b0;
      i_ack_n    = 1'b1;
      d_ack_n    = 1'b1;
      bus_err    = 1'b0;
      err_port   = 1'b0;
      case (state)
         IDLE: begin
            if (grant_d) begin
               state_next = D_BUSY;
            end else if (grant_i) begin
               state_next = I_BUSY;
            end
         end
         I_BUSY, D_BUSY: begin
            m_req = 1'b1;
            if (ack_seen || expired) begin
               state_next = RESP;
            end
         end
         RESP: begin
            state_next = IDLE;
            if (winner == PORT_D) begin
               d_ack_n = 1'b0;
            end else begin
               i_ack_n = 1'b0;
            end
            bus_err  = timed_out;
            err_port = timed_out && (winner == PORT_D);
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Latch the winning request into the memory port in IDLE, then capture
   // read data (or zero it on timeout) as BUSY ends. The m_* registers are
   // only loaded in IDLE, so they are stable for the whole BUSY phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_write   <= 1'b0;
         m_size    <= 2'b00;
         m_addr    <= '0;
         m_wdata   <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         winner    <= PORT_D;
         timed_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  winner    <= PORT_D;
                  m_write   <= d_write;
                  m_size    <= d_size;
                  m_addr    <= d_addr;
                  m_wdata   <= d_write ? d_wdata : '0;
                  timed_out <= 1'b0;
               end else if (grant_i) begin
                  winner    <= PORT_I;
                  m_write   <= 1'b0;
                  m_size    <= SZ_WORD;
                  m_addr    <= i_addr;
                  m_wdata   <= '0;
                  timed_out <= 1'b0;
               end
            end
            I_BUSY, D_BUSY: begin
               if (ack_seen) begin
                  if (!m_write) begin
                     if (winner == PORT_D) begin
                        d_rdata <= m_rdata;
                     end else begin
                        i_rdata <= m_rdata;
                     end
                  end
               end else if (expired) begin
                  timed_out <= 1'b1;
                  if (winner == PORT_D) begin
                     d_rdata <= '0;
                  end else begin
                     i_rdata <= '0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. A behavioural memory acks after a programmable
// number of BUSY cycles; each scenario task pushes the transactions it
// expects onto a scoreboard queue and pops/compares them as acks appear.

module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_ack_n;
   logic        d_req;
   logic        d_write;
   logic [1:0]  d_size;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ack_n;
   logic        m_req;
   logic        m_write;
   logic [1:0]  m_size;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic        m_ack_n;
   logic        bus_err;
   logic        err_port;

   // Memory model controls.
   int          mem_lat   = 0;
   bit          mem_on    = 1'b1;
   bit          stray_ack = 1'b0;
   logic [31:0] rdata_val = '0;
   int          busy_cyc  = 0;

   // Monitor observations.
   int          cyc = 0;
   int          busy_len = 0;
   int          i_ack_cnt = 0;
   int          d_ack_cnt = 0;
   int          err_cycles = 0;
   bit          both_low = 1'b0;
   bit          eport_bad = 1'b0;
   bit          hold_bad = 1'b0;
   logic [31:0] snap_addr;
   logic [31:0] snap_wdata;
   logic [1:0]  snap_size;
   logic        snap_write;
   logic [31:0] obs_rdata;
   logic        obs_err;
   logic        obs_eport;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      bit          port;
      logic [31:0] addr;
      logic [1:0]  size;
      bit          write;
      logic [31:0] wdata;
      logic [31:0] rdata;
      bit          err;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT_CYC(TO)) dut (
      .clk      (clk),
      .rst      (rst),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .i_rdata  (i_rdata),
      .i_ack_n  (i_ack_n),
      .d_req    (d_req),
      .d_write  (d_write),
      .d_size   (d_size),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_rdata  (d_rdata),
      .d_ack_n  (d_ack_n),
      .m_req    (m_req),
      .m_write  (m_write),
      .m_size   (m_size),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_rdata  (m_rdata),
      .m_ack_n  (m_ack_n),
      .bus_err  (bus_err),
      .err_port (err_port)
   );

   // Memory: acks in BUSY cycle number mem_lat (0 = first), or never if off.
   always @(posedge clk) busy_cyc <= m_req ? busy_cyc + 1 : 0;
   assign m_ack_n = !((mem_on && m_req && busy_cyc == mem_lat) || stray_ack);
   assign m_rdata = rdata_val;

   // Passive monitor: snapshot the memory request, track holds, acks and errors.
   always @(negedge clk) begin
      cyc++;
      if (m_req === 1'b1) begin
         busy_len = busy_cyc + 1;
         if (busy_cyc == 0) begin
            snap_addr  = m_addr;
            snap_wdata = m_wdata;
            snap_size  = m_size;
            snap_write = m_write;
         end else if (m_addr !== snap_addr || m_wdata !== snap_wdata ||
                      m_size !== snap_size || m_write !== snap_write) begin
            hold_bad = 1'b1;
         end
      end
      if (i_ack_n === 1'b0) i_ack_cnt++;
      if (d_ack_n === 1'b0) d_ack_cnt++;
      if (i_ack_n === 1'b0 && d_ack_n === 1'b0) both_low = 1'b1;
      if (bus_err === 1'b1) err_cycles++;
      else if (err_port !== 1'b0) eport_bad = 1'b1;
   end

   // Wait (bounded) for either ack; the acked requester then drops its request.
   task automatic wait_ack(input int max_cyc, output bit port, output int waited,
                           output int ack_cyc, output bit ok);
      ok = 1'b0; port = 1'b0; waited = 0; ack_cyc = 0;
      for (int k = 0; k < max_cyc && !ok; k++) begin
         @(negedge clk); #1;
         waited++;
         if (i_ack_n === 1'b0 || d_ack_n === 1'b0) begin
            ok        = 1'b1;
            port      = (d_ack_n === 1'b0);
            ack_cyc   = cyc;
            obs_rdata = port ? d_rdata : i_rdata;
            obs_err   = bus_err;
            obs_eport = err_port;
            if (port) d_req = 1'b0;
            else      i_req = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_total++; if (m_req !== 1'b0) $display("[TB] FAIL reset_m_req: got %b want 0", m_req); else n_pass++;
      n_total++; if (m_write !== 1'b0) $display("[TB] FAIL reset_m_write: got %b want 0", m_write); else n_pass++;
      n_total++; if (m_size !== 2'b00) $display("[TB] FAIL reset_m_size: got %b want 00", m_size); else n_pass++;
      n_total++; if (m_addr !== 32'h0) $display("[TB] FAIL reset_m_addr: got %h want 0", m_addr); else n_pass++;
      n_total++; if (m_wdata !== 32'h0) $display("[TB] FAIL reset_m_wdata: got %h want 0", m_wdata); else n_pass++;
      n_total++; if (i_rdata !== 32'h0) $display("[TB] FAIL reset_i_rdata: got %h want 0", i_rdata); else n_pass++;
      n_total++; if (d_rdata !== 32'h0) $display("[TB] FAIL reset_d_rdata: got %h want 0", d_rdata); else n_pass++;
      n_total++; if (i_ack_n !== 1'b1) $display("[TB] FAIL reset_i_ack_n: got %b want 1", i_ack_n); else n_pass++;
      n_total++; if (d_ack_n !== 1'b1) $display("[TB] FAIL reset_d_ack_n: got %b want 1", d_ack_n); else n_pass++;
      n_total++; if (bus_err !== 1'b0) $display("[TB] FAIL reset_bus_err: got %b want 0", bus_err); else n_pass++;
      n_total++; if (err_port !== 1'b0) $display("[TB] FAIL reset_err_port: got %b want 0", err_port); else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_fetch();
      exp_t e;
      bit port, ok;
      int waited, ack_cyc, base;
      base = i_ack_cnt;
      mem_on = 1'b1; mem_lat = 0; rdata_val = 32'h0000_0013;
      sb.push_back(exp_t'{PORT_I, 32'h100, SZ_WORD, 1'b0, 32'h0, 32'h0000_0013, 1'b0});
      @(negedge clk); #1;
      i_addr = 32'h100; i_req = 1'b1;
      wait_ack(20, port, waited, ack_cyc, ok);
      e = sb.pop_front();
      n_total++;
      if (!ok) $display("[TB] FAIL fetch_ack: got no ack want ack within 20 cycles");
      else begin
         n_pass++;
         n_total++; if (port !== e.port) $display("[TB] FAIL fetch_port: got %b want %b", port, e.port); else n_pass++;
         n_total++; if (snap_addr !== e.addr) $display("[TB] FAIL fetch_m_addr: got %h want %h", snap_addr, e.addr); else n_pass++;
         n_total++; if (snap_size !== e.size) $display("[TB] FAIL fetch_m_size: got %b want %b", snap_size, e.size); else n_pass++;
         n_total++; if (snap_write !== e.write) $display("[TB] FAIL fetch_m_write: got %b want %b", snap_write, e.write); else n_pass++;
         n_total++; if (snap_wdata !== e.wdata) $display("[TB] FAIL fetch_m_wdata: got %h want %h", snap_wdata, e.wdata); else n_pass++;
         n_total++; if (obs_rdata !== e.rdata) $display("[TB] FAIL fetch_i_rdata: got %h want %h", obs_rdata, e.rdata); else n_pass++;
         n_total++; if (obs_err !== e.err) $display("[TB] FAIL fetch_bus_err: got %b want %b", obs_err, e.err); else n_pass++;
         n_total++; if (waited != 2) $display("[TB] FAIL fetch_latency: got %0d want 2", waited); else n_pass++;
      end
      repeat (3) @(negedge clk);
      #1;
      n_total++; if (i_ack_cnt - base != 1) $display("[TB] FAIL fetch_ack_count: got %0d want 1", i_ack_cnt - base); else n_pass++;
      n_total++; if (m_req !== 1'b0) $display("[TB] FAIL fetch_idle_m_req: got %b want 0", m_req); else n_pass++;
   endtask

   task automatic test_data();
      exp_t e;
      bit port, ok;
      int waited, ack_cyc;
      logic        t_write[2];
      logic [1:0]  t_size[2];
      logic [31:0] t_addr[2];
      logic [31:0] t_wdata[2];
      logic [31:0] t_mem[2];
      int          t_lat[2];
      // Load first so the store can show d_rdata is left alone.
      t_write[0] = 1'b0; t_size[0] = SZ_HALF; t_addr[0] = 32'h300; t_wdata[0] = 32'hDEAD_BEEF;
      t_mem[0] = 32'hCAFE_F00D; t_lat[0] = 2;
      t_write[1] = 1'b1; t_size[1] = SZ_BYTE; t_addr[1] = 32'h203; t_wdata[1] = 32'h0000_00AB;
      t_mem[1] = 32'h1111_1111; t_lat[1] = 1;
      for (int t = 0; t < 2; t++) begin
         hold_bad = 1'b0;
         mem_on = 1'b1; mem_lat = t_lat[t]; rdata_val = t_mem[t];
         sb.push_back(exp_t'{PORT_D, t_addr[t], t_size[t], t_write[t],
                             t_write[t] ? t_wdata[t] : 32'h0,
                             t_write[t] ? 32'hCAFE_F00D : t_mem[t], 1'b0});
         @(negedge clk); #1;
         d_write = t_write[t]; d_size = t_size[t]; d_addr = t_addr[t]; d_wdata = t_wdata[t];
         d_req = 1'b1;
         wait_ack(20, port, waited, ack_cyc, ok);
         e = sb.pop_front();
         n_total++;
         if (!ok) $display("[TB] FAIL data%0d_ack: got no ack want ack within 20 cycles", t);
         else begin
            n_pass++;
            n_total++; if (port !== e.port) $display("[TB] FAIL data%0d_port: got %b want %b", t, port, e.port); else n_pass++;
            n_total++; if (snap_addr !== e.addr) $display("[TB] FAIL data%0d_m_addr: got %h want %h", t, snap_addr, e.addr); else n_pass++;
            n_total++; if (snap_size !== e.size) $display("[TB] FAIL data%0d_m_size: got %b want %b", t, snap_size, e.size); else n_pass++;
            n_total++; if (snap_write !== e.write) $display("[TB] FAIL data%0d_m_write: got %b want %b", t, snap_write, e.write); else n_pass++;
            n_total++; if (snap_wdata !== e.wdata) $display("[TB] FAIL data%0d_m_wdata: got %h want %h", t, snap_wdata, e.wdata); else n_pass++;
            n_total++; if (obs_rdata !== e.rdata) $display("[TB] FAIL data%0d_d_rdata: got %h want %h", t, obs_rdata, e.rdata); else n_pass++;
            n_total++; if (hold_bad !== 1'b0) $display("[TB] FAIL data%0d_hold: got change want stable m_* in BUSY", t); else n_pass++;
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      bit port, ok;
      int waited, ack_cyc, prev_cyc;
      both_low = 1'b0;
      mem_on = 1'b1; mem_lat = 0;
      for (int r = 0; r < 2; r++) begin
         exp_t ei, ed;
         rdata_val = 32'h5A5A_0000 + r;
         ei = exp_t'{PORT_I, 32'h1000 + 16 * r, SZ_WORD, 1'b0, 32'h0, 32'h5A5A_0000 + r, 1'b0};
         ed = exp_t'{PORT_D, 32'h2000 + 16 * r, SZ_WORD, 1'b0, 32'h0, 32'h5A5A_0000 + r, 1'b0};
`ifdef MEM_ARB_RR_EN
         sb.push_back(ei); sb.push_back(ed);
`else
         sb.push_back(ed); sb.push_back(ei);
`endif
         @(negedge clk); #1;
         i_addr = 32'h1000 + 16 * r; d_addr = 32'h2000 + 16 * r;
         d_write = 1'b0; d_size = SZ_WORD; d_wdata = 32'h0;
         i_req = 1'b1; d_req = 1'b1;
         prev_cyc = -1;
         for (int k = 0; k < 2; k++) begin
            wait_ack(20, port, waited, ack_cyc, ok);
            e = sb.pop_front();
            n_total++;
            if (!ok) $display("[TB] FAIL tie%0d_%0d_ack: got no ack want ack within 20 cycles", r, k);
            else begin
               n_pass++;
               n_total++; if (port !== e.port) $display("[TB] FAIL tie%0d_%0d_order: got port %b want %b", r, k, port, e.port); else n_pass++;
               n_total++; if (snap_addr !== e.addr) $display("[TB] FAIL tie%0d_%0d_m_addr: got %h want %h", r, k, snap_addr, e.addr); else n_pass++;
               n_total++; if (obs_rdata !== e.rdata) $display("[TB] FAIL tie%0d_%0d_rdata: got %h want %h", r, k, obs_rdata, e.rdata); else n_pass++;
               if (k == 1) begin
                  n_total++; if (ack_cyc == prev_cyc) $display("[TB] FAIL tie%0d_distinct: got both acks in cycle %0d want distinct", r, ack_cyc); else n_pass++;
               end
               prev_cyc = ack_cyc;
            end
         end
         i_req = 1'b0; d_req = 1'b0;
      end
      n_total++; if (both_low !== 1'b0) $display("[TB] FAIL tie_both_acks_low: got 1 want 0"); else n_pass++;
   endtask

   task automatic test_stray_ack();
      int bi, bd;
      bit req_seen;
      bi = i_ack_cnt; bd = d_ack_cnt; req_seen = 1'b0;
      @(negedge clk); #1;
      stray_ack = 1'b1;
      repeat (3) begin
         @(negedge clk); #1;
         if (m_req !== 1'b0) req_seen = 1'b1;
      end
      stray_ack = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_total++; if (req_seen !== 1'b0) $display("[TB] FAIL stray_m_req: got 1 want 0"); else n_pass++;
      n_total++; if ((i_ack_cnt - bi) + (d_ack_cnt - bd) != 0) $display("[TB] FAIL stray_acks: got %0d want 0", (i_ack_cnt - bi) + (d_ack_cnt - bd)); else n_pass++;
   endtask

   task automatic test_timeout();
      exp_t e;
      bit port, ok;
      int waited, ack_cyc, base_err;
      base_err = err_cycles; eport_bad = 1'b0;
      mem_on = 1'b0;
      sb.push_back(exp_t'{PORT_D, 32'h400, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b1});
      @(negedge clk); #1;
      d_write = 1'b0; d_size = SZ_WORD; d_addr = 32'h400; d_wdata = 32'h0;
      d_req = 1'b1;
      wait_ack(20, port, waited, ack_cyc, ok);
      e = sb.pop_front();
      n_total++;
      if (!ok) $display("[TB] FAIL timeout_ack: got no ack want ack within 20 cycles");
      else begin
         n_pass++;
         n_total++; if (port !== e.port) $display("[TB] FAIL timeout_port: got %b want %b", port, e.port); else n_pass++;
         n_total++; if (busy_len != TO) $display("[TB] FAIL timeout_busy_len: got %0d want %0d", busy_len, TO); else n_pass++;
         n_total++; if (obs_err !== e.err) $display("[TB] FAIL timeout_bus_err: got %b want %b", obs_err, e.err); else n_pass++;
         n_total++; if (obs_eport !== 1'b1) $display("[TB] FAIL timeout_err_port: got %b want 1", obs_eport); else n_pass++;
         n_total++; if (obs_rdata !== e.rdata) $display("[TB] FAIL timeout_d_rdata: got %h want %h", obs_rdata, e.rdata); else n_pass++;
      end
      mem_on = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_total++; if (err_cycles - base_err != 1) $display("[TB] FAIL timeout_err_len: got %0d want 1", err_cycles - base_err); else n_pass++;
      n_total++; if (eport_bad !== 1'b0) $display("[TB] FAIL timeout_err_port_idle: got 1 want 0"); else n_pass++;
   endtask

   task automatic test_ack_at_limit();
      exp_t e;
      bit port, ok;
      int waited, ack_cyc;
      mem_on = 1'b1; mem_lat = TO - 1; rdata_val = 32'h600D_F00D;
      sb.push_back(exp_t'{PORT_I, 32'h500, SZ_WORD, 1'b0, 32'h0, 32'h600D_F00D, 1'b0});
      @(negedge clk); #1;
      i_addr = 32'h500; i_req = 1'b1;
      wait_ack(20, port, waited, ack_cyc, ok);
      e = sb.pop_front();
      n_total++;
      if (!ok) $display("[TB] FAIL limit_ack: got no ack want ack within 20 cycles");
      else begin
         n_pass++;
         n_total++; if (busy_len != TO) $display("[TB] FAIL limit_busy_len: got %0d want %0d", busy_len, TO); else n_pass++;
         n_total++; if (obs_err !== e.err) $display("[TB] FAIL limit_bus_err: got %b want %b", obs_err, e.err); else n_pass++;
         n_total++; if (obs_rdata !== e.rdata) $display("[TB] FAIL limit_i_rdata: got %h want %h", obs_rdata, e.rdata); else n_pass++;
      end
      mem_lat = 0;
   endtask

   task automatic test_reset_busy();
      bit seen;
      int bi, bd, be;
      mem_on = 1'b0; seen = 1'b0;
      @(negedge clk); #1;
      d_write = 1'b0; d_size = SZ_WORD; d_addr = 32'h700; d_req = 1'b1;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk); #1;
         if (m_req === 1'b1) seen = 1'b1;
      end
      n_total++;
      if (!seen) $display("[TB] FAIL rstbusy_enter: got no BUSY want BUSY within 10 cycles");
      else n_pass++;
      bi = i_ack_cnt; bd = d_ack_cnt; be = err_cycles;
      rst = 1'b1;
      @(negedge clk); #1;
      n_total++; if (m_req !== 1'b0) $display("[TB] FAIL rstbusy_m_req: got %b want 0", m_req); else n_pass++;
      n_total++; if (d_ack_n !== 1'b1) $display("[TB] FAIL rstbusy_d_ack_n: got %b want 1", d_ack_n); else n_pass++;
      d_req = 1'b0; rst = 1'b0; mem_on = 1'b1;
      repeat (TO + 4) @(negedge clk);
      #1;
      n_total++; if (d_ack_cnt - bd + i_ack_cnt - bi != 0) $display("[TB] FAIL rstbusy_no_ack: got %0d acks want 0", d_ack_cnt - bd + i_ack_cnt - bi); else n_pass++;
      n_total++; if (err_cycles - be != 0) $display("[TB] FAIL rstbusy_no_err: got %0d want 0", err_cycles - be); else n_pass++;
      n_total++; if (d_rdata !== 32'h0) $display("[TB] FAIL rstbusy_d_rdata: got %h want 0", d_rdata); else n_pass++;
   endtask

   initial begin
      rst = 1'b1;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_write = 1'b0; d_size = '0; d_addr = '0; d_wdata = '0;
      test_reset();
      test_fetch();
      test_data();
      test_back_to_back();
      test_stray_ack();
      test_timeout();
      test_ack_at_limit();
      test_reset_busy();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish want finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: cycles to wait in a busy state for a memory ack; 0 disables the timeout.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports i_req in 1 (fetch request), i_addr in 32 (fetch address), i_rdata out 32 (fetched instruction) and i_ack_n out 1 (active-low fetch done).
REQ-005 SHALL have ports d_req in 1, d_write in 1, d_size in 2, d_addr in 32, d_wdata in 32, d_rdata out 32 and d_ack_n out 1, all for data load/store.
REQ-006 SHALL have ports m_req out 1, m_write out 1, m_size out 2, m_addr out 32, m_wdata out 32, m_rdata in 32 and m_ack_n in 1, forming the single shared memory port.
REQ-007 SHALL have ports bus_err out 1 (timeout indication) and err_port out 1 (0 = fetch, 1 = data).

Function
REQ-008 SHALL implement FSM states IDLE, I_BUSY, D_BUSY and RESP.
REQ-009 IDLE: if d_req or i_req is sampled high, SHALL register the winner's address, size and write data into m_* and go to the matching BUSY state; with no request it SHALL stay in IDLE.
REQ-010 Tie (both requests high in IDLE), default: data wins.
REQ-011 m_req SHALL be 1 only in BUSY states; m_addr, m_size, m_write and m_wdata SHALL stay constant throughout BUSY.
REQ-012 Fetch transfers SHALL drive m_write=0, m_size=2'b10 (word) and m_wdata=0.
REQ-013 Data transfers SHALL drive m_write=d_write, m_size=d_size, m_addr=d_addr and m_wdata=d_wdata; m_wdata SHALL be 0 for loads.
REQ-014 BUSY with m_ack_n=0 sampled: SHALL capture m_rdata into the winner's rdata register (reads only; writes leave it unchanged) and go to RESP.
REQ-015 RESP: SHALL drive the winner's ack_n=0 for exactly one cycle, ignore all requests, then return to IDLE.
REQ-016 Minimum transaction SHALL take 3 cycles (IDLE sample -> BUSY with same-cycle ack -> RESP); the requester sees ack 2 cycles after its request is sampled.
REQ-017 Requesters SHALL hold req and payload until they see their ack; the arbiter SHALL use only values sampled in IDLE.
REQ-018 m_ack_n=0 sampled outside BUSY SHALL be ignored.
REQ-019 Timeout: a counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack; on reaching TIMEOUT_CYC the FSM SHALL go to RESP with the winner's rdata=32'h0.
REQ-020 On timeout, bus_err=1 and err_port=winner SHALL hold for the RESP cycle only; err_port SHALL be 0 whenever bus_err=0.
REQ-021 If ack and timeout coincide, ack SHALL win and no bus_err SHALL be raised.
REQ-022 i_ack_n and d_ack_n SHALL never be low in the same cycle.

Reset
REQ-023 While rst=1 the FSM SHALL go to IDLE from any state, abandoning any transaction in flight with no ack issued.
REQ-024 Reset values: m_req=0, m_write=0, m_size=0, m_addr=0, m_wdata=0, i_rdata=0, d_rdata=0, i_ack_n=1, d_ack_n=1, bus_err=0, err_port=0, timeout counter=0, last-grant=data.

Configuration
REQ-025 Macro MEM_ARB_RR_EN defined: ties SHALL go to the port not granted last; last-grant SHALL update on every grant and reset to data, so the first tie goes to fetch.
REQ-026 Macro undefined: fixed data priority and no last-grant register.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, size constants (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10) and port ids (PORT_I=0, PORT_D=1).
REQ-028 The timeout counter SHALL be sub-module bus_timeout, with ports clk, rst, clr, en and expired, parameterised by TIMEOUT_CYC.

Verification
REQ-029 Single fetch: i_req=1 with i_addr=0x100, memory acks in its first BUSY cycle with 0x00000013 -> m_addr=0x100, m_size=2'b10, i_ack_n low exactly once, i_rdata=0x00000013.
REQ-030 Tie, MEM_ARB_RR_EN undefined: both requests high -> data served first, fetch second, with the two acks in distinct cycles.
REQ-031 Tie, MEM_ARB_RR_EN defined: two consecutive ties -> grant order fetch, data, fetch, data.
REQ-032 Store: d_write=1, d_size=2'b00, d_addr=0x203, d_wdata=0xAB -> m_write=1, m_size=2'b00, m_addr=0x203, m_wdata=0xAB, d_rdata unchanged.
REQ-033 TIMEOUT_CYC=4 with no memory ack -> RESP entered after 4 BUSY cycles, bus_err=1 and err_port=1 for one cycle, d_rdata=0.
REQ-034 rst=1 during D_BUSY -> next cycle m_req=0, no ack issued, FSM in IDLE.
